osd_spi_ctrl: RTL
=================

OSD_SPI_CTRL -- requirements
Module: osd_spi_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, gives clk cycles per SCK half-period; legal range 1..255.
REQ-002 Parameter SS_GAP, default 4, gives the minimum clk cycles SS stays high between transactions; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state is clocked on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-007 cmd_op  in  2  opcode: 00 disable OSD, 01 enable OSD, 10 write line, 11 reserved.
REQ-008 cmd_line  in  3  OSD line (0..7), used by write only.
REQ-009 mem_rd  out  1  one-cycle read strobe to the line-source RAM.
REQ-010 mem_addr  out  11  read address {line[2:0], byte[7:0]}.
REQ-011 mem_data  in  8  read data, valid exactly one clk after mem_rd.
REQ-012 sck  out  1  SPI clock, idles low.
REQ-013 ss  out  1  SPI select, active low, idles high.
REQ-014 sdi  out  1  SPI data, MSB first.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 done  out  1  one-cycle pulse when a command completes.

Function
REQ-017 FSM states: IDLE, START, FETCH, LOAD, SHIFT, NEXT, STOP, GAP.
REQ-018 cmd_ready is high only in IDLE; on acceptance, latch cmd_op and cmd_line, then go to START.
REQ-019 cmd_op 11: accept, emit no SPI activity, pulse done on the next cycle, return to IDLE.
REQ-020 Command byte: disable = 0x40, enable = 0x41, write = 0x20 | cmd_line.
REQ-021 START: drive ss low with sck low; load the command byte into an 8-bit shift register; sdi = bit7; hold for CLK_DIV cycles, then go to SHIFT.
REQ-022 SHIFT: sck high for CLK_DIV cycles, then low for CLK_DIV cycles, per bit.
REQ-023 On each sck falling edge, shift left and update sdi, so sdi is stable for CLK_DIV cycles before every sck rise.
REQ-024 An 8-bit byte therefore takes 16*CLK_DIV cycles in SHIFT.
REQ-025 After the 8th falling edge, go to NEXT with sck low and ss still low.
REQ-026 NEXT for enable/disable: go to STOP.
REQ-027 NEXT for write: if the payload byte counter (9 bits, reset to 0 at START) equals 256, go to STOP; otherwise go to FETCH.
REQ-028 FETCH: mem_rd = 1 for exactly one cycle, with mem_addr = {line, counter[7:0]}.
REQ-029 LOAD: capture mem_data into the shift register, set sdi = mem_data[7], increment the counter, wait CLK_DIV cycles with sck low, then go to SHIFT.
REQ-030 A write transaction is therefore 1 command byte plus exactly 256 payload bytes, addresses 0..255 in order, with no repeats or skips.
REQ-031 STOP: hold sck low and ss low for CLK_DIV cycles, then drive ss high and go to GAP.
REQ-032 GAP: hold ss high for SS_GAP cycles, pulse done on the last GAP cycle, then go to IDLE.
REQ-033 mem_rd is never asserted outside FETCH; mem_addr holds its last value otherwise.
REQ-034 sck toggles only while ss is low; sck is low whenever ss changes.
REQ-035 cmd_valid and cmd inputs are ignored while busy; a held cmd_valid is accepted on the first IDLE cycle.
REQ-036 cmd_line is ignored for enable/disable.
REQ-037 All half-period counters are 8 bits and reload on every state entry.

Reset
REQ-038 rst_n low, including mid-transaction, immediately forces: state IDLE, ss = 1, sck = 0, sdi = 0, mem_rd = 0, mem_addr = 0, done = 0, busy = 0, cmd_ready = 0 while reset is held, and all counters 0.
REQ-039 cmd_ready = 1 on the first clk edge after rst_n deasserts.
REQ-040 No partial command is resumed after reset.

Verification
REQ-041 Enable, CLK_DIV = 2: cmd_op = 01 -> one ss-low window; 8 sck rises, each 4 clk apart; SPI slave model captures 0x41; done pulses once after 4 GAP cycles.
REQ-042 Write line 5, RAM[0x500+i] = i ^ 0xA5 -> slave captures 0x25 then 256 bytes, i ^ 0xA5 for i = 0..255; mem_rd count = 256; addresses 0x500..0x5FF in order.
REQ-043 Reserved op 11 -> ss never falls; done pulses one cycle after acceptance; busy high for 1 cycle.
REQ-044 Back-to-back: enable then write line 0 with cmd_valid held high -> second accept occurs only after done; ss-high gap is at least SS_GAP cycles; sck is low at every ss edge.
REQ-045 Reset asserted at payload byte 100 of a write -> ss = 1, sck = 0 within the same cycle; a subsequent write line 7 completes with 257 bytes correct.
REQ-046 CLK_DIV = 1 corner case: a disable command completes with sck period 2 clk; slave captures 0x40.

Source files
------------

// File: rtl/osd_spi_ctrl.sv
// SPI master that sends OSD enable/disable commands and streams one 256-byte
// OSD line from the line-source RAM behind a write command.
module osd_spi_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_line,
  output logic        mem_rd,
  output logic [10:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        sck,
  output logic        ss,
  output logic        sdi,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = 8;
  localparam int unsigned BW = 9;
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LOAD_END = CW'(CLK_DIV);
  localparam logic [CW-1:0] GAP_END  = CW'(SS_GAP - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(256);

  localparam logic [1:0] OP_DIS = 2'b00;
  localparam logic [1:0] OP_EN  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {IDLE, START, FETCH, LOAD, SHIFT, NEXT, STOP, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    op_q, op_d;
  logic [2:0]    line_q, line_d;
  logic          ss_q, ss_d, sck_q, sck_d, sdi_q, sdi_d;
  logic          mem_rd_q, mem_rd_d;
  logic [10:0]   mem_addr_q, mem_addr_d;
  logic          done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic          accept, half_done;
  logic [7:0]    cmd_byte;

  assign accept    = cmd_valid & ready_q;
  assign half_done = (cnt_q == HALF_END);

  always_comb begin : cmd_byte_dec
    case (cmd_op)
      OP_DIS:  cmd_byte = 8'h40;
      OP_EN:   cmd_byte = 8'h41;
      default: cmd_byte = {5'b00100, cmd_line};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START: begin
        if (op_q == OP_RSV) state_d = IDLE;
        else if (half_done) state_d = SHIFT;
      end
      SHIFT:   if (half_done && sck_q && bit_q == 3'd7) state_d = NEXT;
      NEXT:    state_d = (op_q != OP_WR || byte_q == LAST_BYTE) ? STOP : FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    if (cnt_q == LOAD_END) state_d = SHIFT;
      STOP:    if (half_done) state_d = GAP;
      GAP:     if (cnt_q == GAP_END) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : output_dec
    cnt_d      = (state_d != state_q) ? '0 : cnt_q + 8'd1;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shreg_d    = shreg_q;
    op_d       = op_q;
    line_d     = line_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    sdi_d      = sdi_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    busy_d     = (state_d != IDLE);
    ready_d    = (state_d == IDLE);
    done_d     = (state_d == GAP) && (cnt_d == GAP_END);
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          line_d = cmd_line;
          byte_d = '0;
          if (cmd_op != OP_RSV) begin
            ss_d    = 1'b0;
            sck_d   = 1'b0;
            shreg_d = cmd_byte;
            sdi_d   = cmd_byte[7];
          end
        end
      end
      START: begin
        if (op_q == OP_RSV) done_d = 1'b1;
        else if (half_done) begin
          sck_d = 1'b1;
          bit_d = '0;
        end
      end
      SHIFT: begin
        // sdi moves only on the falling edge, leaving a full half-period of setup
        if (half_done) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d   = 1'b0;
            shreg_d = {shreg_q[6:0], 1'b0};
            sdi_d   = shreg_q[6];
            bit_d   = bit_q + 3'd1;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      NEXT: begin
        if (state_d == FETCH) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {line_q, byte_q[7:0]};
        end
      end
      LOAD: begin
        // RAM data is valid in the first LOAD cycle; the rest is sdi setup time
        if (cnt_q == '0) begin
          shreg_d = mem_data;
          sdi_d   = mem_data[7];
          byte_d  = byte_q + 9'd1;
        end
        if (state_d == SHIFT) begin
          sck_d = 1'b1;
          bit_d = '0;
        end
      end
      STOP:    if (half_done) ss_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath_reg
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      op_q       <= '0;
      line_q     <= '0;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      op_q       <= op_d;
      line_q     <= line_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign sdi       = sdi_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
